// File: rtl/mem_arbiter_pkg.sv
// Shared types for the core memory-port arbiter.
//   arb_state_e : arbiter FSM state (IDLE, REQ, RESP, ERR)
//   arb_owner_e : which master owns the transaction in flight
//   mem_req_t   : request payload captured at grant and replayed to memory
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2,
    ARB_ERR  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_IFU = 1'b0,
    ARB_OWNER_LSU = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single core memory port between the IFU (read-only
// fetch) and the LSU (loads/stores). One transaction is outstanding at a time.
// LSU has fixed priority over IFU. The granted request is latched and replayed
// to memory; the response is routed back to the owning master. A watchdog turns
// a hung access into an error response.
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   ifu_req_*/ifu_addr               IFU request channel (handshake valid & ready)
//   ifu_resp_*/ifu_rdata             IFU response channel
//   lsu_req_*/lsu_addr/wen/wdata/wmask  LSU request channel
//   lsu_resp_*/lsu_rdata             LSU response channel
//   mem_req_*/mem_addr/wen/wdata/wmask  request to memory (latched payload)
//   mem_resp_*/mem_rdata             response from memory
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in REQ+RESP before an error response (0 = off)
//   CNT_W           watchdog counter width, must hold TIMEOUT_CYCLES
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  output logic        mem_resp_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err
);

  localparam logic             WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q;
  arb_owner_e       owner_q;
  mem_req_t         req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic owner_resp_ready;
  logic resp_hs;
  logic wd_expire;
  logic owner_resp_active;

  always_comb begin
    owner_resp_ready = (owner_q == ARB_OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;
    resp_hs          = mem_resp_valid && owner_resp_ready;
    // Saturating increment so a disabled/oversized watchdog never wraps.
    cnt_d            = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    wd_expire        = WD_EN && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWNER_IFU;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (lsu_req_valid) begin
            req_q   <= '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
            owner_q <= ARB_OWNER_LSU;
            cnt_q   <= '0;
            state_q <= ARB_REQ;
          end else if (ifu_req_valid) begin
            // Fetches are always reads regardless of whatever sits on the bus.
            req_q   <= '{addr: ifu_addr, wen: 1'b0, wdata: 32'd0, wmask: 4'd0};
            owner_q <= ARB_OWNER_IFU;
            cnt_q   <= '0;
            state_q <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          cnt_q <= cnt_d;
          if (mem_req_ready) begin
            state_q <= ARB_RESP;
          end else if (wd_expire) begin
            state_q <= ARB_ERR;
          end
        end
        ARB_RESP: begin
          cnt_q <= cnt_d;
          if (resp_hs) begin
            state_q <= ARB_IDLE;
          end else if (wd_expire) begin
            state_q <= ARB_ERR;
          end
        end
        default: begin
          if (owner_resp_ready) begin
            state_q <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  // Master readies are masked while reset is held so nothing is acked during it.
  assign lsu_req_ready = (state_q == ARB_IDLE) && !reset;
  assign ifu_req_ready = (state_q == ARB_IDLE) && !reset && !lsu_req_valid;

  assign mem_req_valid = (state_q == ARB_REQ);
  assign mem_addr      = req_q.addr;
  assign mem_wen       = req_q.wen;
  assign mem_wdata     = req_q.wdata;
  assign mem_wmask     = req_q.wmask;

  // IDLE and ERR swallow any response (stray or from a slave declared dead).
  always_comb begin
    case (state_q)
      ARB_RESP: mem_resp_ready = owner_resp_ready;
      ARB_REQ:  mem_resp_ready = 1'b0;
      default:  mem_resp_ready = 1'b1;
    endcase
  end

  assign owner_resp_active = ((state_q == ARB_RESP) && mem_resp_valid) || (state_q == ARB_ERR);
  assign lsu_resp_valid    = owner_resp_active && (owner_q == ARB_OWNER_LSU);
  assign ifu_resp_valid    = owner_resp_active && (owner_q == ARB_OWNER_IFU);

  assign lsu_rdata    = (state_q == ARB_ERR) ? 32'd0 : mem_rdata;
  assign ifu_rdata    = (state_q == ARB_ERR) ? 32'd0 : mem_rdata;
  assign lsu_resp_err = (state_q == ARB_ERR) || mem_resp_err;
  assign ifu_resp_err = (state_q == ARB_ERR) || mem_resp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (watchdog set to 8 cycles). Inputs are
// driven 1 ns after the rising edge, outputs sampled 1 ns later.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_req_valid = 0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 0, ifu_resp_err;
  logic [31:0] ifu_addr = 0, ifu_rdata;
  logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_resp_valid, lsu_resp_ready = 0, lsu_resp_err;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
  logic [3:0]  lsu_wmask = 0;
  logic        mem_req_valid, mem_req_ready = 0, mem_wen, mem_resp_valid = 0, mem_resp_ready, mem_resp_err = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .mem_resp_err(mem_resp_err)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    settle();
    checks++; if ({lsu_req_ready, ifu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_resp_ready} !== 6'b000001) begin
      errors++; $display("FAIL reset_outputs got %b want 000001", {lsu_req_ready, ifu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, mem_resp_ready}); end
    checks++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== 69'd0) begin
      errors++; $display("FAIL reset_payload got %h want 0", {mem_addr, mem_wen, mem_wdata, mem_wmask}); end
    tick();
    reset = 1'b0;
    settle();
    checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b11) begin
      errors++; $display("FAIL idle_ready got %b want 11", {lsu_req_ready, ifu_req_ready}); end
    $display("test_reset done");
    tick();
  endtask

  // Single fetch at minimum latency: ack cyc0, mem req cyc1, response cyc2.
  task automatic test_ifu_only();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    settle();
    checks++; if ({ifu_req_ready, mem_req_valid} !== 2'b10) begin
      errors++; $display("FAIL t1_cyc0 ready/memvalid got %b want 10", {ifu_req_ready, mem_req_valid}); end
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    settle();
    checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin
      errors++; $display("FAIL t1_cyc1 mem req got %b %h %b %h", mem_req_valid, mem_addr, mem_wen, mem_wmask); end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0413; mem_resp_err = 0; ifu_resp_ready = 1;
    settle();
    checks++; if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata, ifu_resp_err, mem_resp_ready} !== {2'b10, 32'h413, 2'b01}) begin
      errors++; $display("FAIL t1_cyc2 resp got v=%b lv=%b d=%h e=%b mr=%b", ifu_resp_valid, lsu_resp_valid, ifu_rdata, ifu_resp_err, mem_resp_ready); end
    tick();
    mem_resp_valid = 0; ifu_resp_ready = 0;
    settle();
    checks++; if ({ifu_resp_valid, ifu_req_ready} !== 2'b01) begin
      errors++; $display("FAIL t1_back_idle got %b want 01", {ifu_resp_valid, ifu_req_ready}); end
    $display("test_ifu_only done");
  endtask

  task automatic test_priority();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    settle();
    checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
      errors++; $display("FAIL t2_grant got lsu/ifu ready %b want 10", {lsu_req_ready, ifu_req_ready}); end
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    settle();
    checks++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready} !== {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
      errors++; $display("FAIL t2_lsu_payload got %h %b %h %h ifu_rdy=%b", mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_req_ready); end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678; lsu_resp_ready = 1;
    settle();
    checks++; if ({lsu_resp_valid, ifu_resp_valid, ifu_req_ready} !== 3'b100) begin
      errors++; $display("FAIL t2_lsu_resp got lv/iv/irdy %b want 100", {lsu_resp_valid, ifu_resp_valid, ifu_req_ready}); end
    tick();
    mem_resp_valid = 0; lsu_resp_ready = 0;
    settle();
    checks++; if (ifu_req_ready !== 1'b1) begin
      errors++; $display("FAIL t2_ifu_ack got %b want 1", ifu_req_ready); end
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    settle();
    checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, 32'h8000_0040, 1'b0, 4'h0}) begin
      errors++; $display("FAIL t2_ifu_payload got %b %h %b %h", mem_req_valid, mem_addr, mem_wen, mem_wmask); end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; ifu_resp_ready = 1;
    settle();
    checks++; if (ifu_resp_valid !== 1'b1) begin
      errors++; $display("FAIL t2_ifu_resp got %b want 1", ifu_resp_valid); end
    tick();
    mem_resp_valid = 0; ifu_resp_ready = 0; lsu_wen = 0;
    $display("test_priority done");
  endtask

  task automatic test_backpressure();
    lsu_req_valid = 1; lsu_addr = 32'h8000_2008; lsu_wen = 1; lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'h3;
    tick();
    lsu_req_valid = 0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'h0; lsu_wen = 0;
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== {1'b1, 32'h8000_2008, 1'b1, 32'hCAFE_F00D, 4'h3}) begin
        errors++; $display("FAIL t3_req_stall%0d got %b %h %b %h %h", k, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask); end
      tick();
    end
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    mem_resp_valid = 1; mem_rdata = 32'h0; lsu_resp_ready = 1; tick();
    mem_resp_valid = 0; lsu_resp_ready = 0;
    // Second transaction: response held off by the LSU.
    lsu_req_valid = 1; lsu_addr = 32'h8000_200C; tick();
    lsu_req_valid = 0; mem_req_ready = 1; tick(); mem_req_ready = 0;
    mem_resp_valid = 1; mem_rdata = 32'h5A5A_0FF0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if ({lsu_resp_valid, mem_resp_ready, lsu_rdata} !== {2'b10, 32'h5A5A_0FF0}) begin
        errors++; $display("FAIL t3_resp_stall%0d got v=%b mr=%b d=%h", k, lsu_resp_valid, mem_resp_ready, lsu_rdata); end
      tick();
    end
    lsu_resp_ready = 1;
    settle();
    checks++; if (mem_resp_ready !== 1'b1) begin
      errors++; $display("FAIL t3_resp_release got %b want 1", mem_resp_ready); end
    tick();
    mem_resp_valid = 0; lsu_resp_ready = 0;
    $display("test_backpressure done");
  endtask

  // Error response appears TIMEOUT (8) cycles after mem_req_valid first rises.
  task automatic test_timeout();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100; mem_rdata = 32'hA5A5_A5A5;
    tick();
    ifu_req_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      settle();
      checks++; if ({mem_req_valid, ifu_resp_valid} !== 2'b10) begin
        errors++; $display("FAIL t4_wait%0d got memv/ifuv %b want 10", k, {mem_req_valid, ifu_resp_valid}); end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      ifu_resp_ready = (k == 1);
      settle();
      checks++; if ({mem_req_valid, ifu_resp_valid, ifu_resp_err, ifu_rdata, mem_resp_ready, lsu_resp_valid} !== {3'b011, 32'd0, 2'b10}) begin
        errors++; $display("FAIL t4_err%0d got mv=%b v=%b e=%b d=%h mr=%b lv=%b", k, mem_req_valid, ifu_resp_valid, ifu_resp_err, ifu_rdata, mem_resp_ready, lsu_resp_valid); end
      tick();
    end
    ifu_resp_ready = 0;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0200;
    settle();
    checks++; if (lsu_req_ready !== 1'b1) begin
      errors++; $display("FAIL t4_regrant got %b want 1", lsu_req_ready); end
    tick();
    lsu_req_valid = 0; mem_req_ready = 1; tick(); mem_req_ready = 0;
    mem_resp_valid = 1; lsu_resp_ready = 1; tick();
    mem_resp_valid = 0; lsu_resp_ready = 0;
    $display("test_timeout done");
  endtask

  task automatic test_stray();
    for (int k = 0; k < 2; k++) begin
      mem_resp_valid = 1; mem_rdata = 32'h0BAD_0000 + k; ifu_resp_ready = 1; lsu_resp_ready = 1;
      settle();
      checks++; if ({mem_resp_ready, ifu_resp_valid, lsu_resp_valid, lsu_req_ready} !== 4'b1001) begin
        errors++; $display("FAIL t5_stray%0d got mr/iv/lv/rdy %b want 1001", k, {mem_resp_ready, ifu_resp_valid, lsu_resp_valid, lsu_req_ready}); end
      tick();
    end
    mem_resp_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
    $display("test_stray done");
  endtask

  task automatic test_reset_mid();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0044; tick();
    lsu_req_valid = 0; mem_req_ready = 1; tick(); mem_req_ready = 0;
    reset = 1; tick();
    reset = 0; mem_resp_valid = 1; mem_rdata = 32'hFEED_FACE; lsu_resp_ready = 1;
    settle();
    checks++; if ({lsu_resp_valid, ifu_resp_valid, mem_resp_ready, lsu_req_ready} !== 4'b0011) begin
      errors++; $display("FAIL t6_after_reset got lv/iv/mr/rdy %b want 0011", {lsu_resp_valid, ifu_resp_valid, mem_resp_ready, lsu_req_ready}); end
    tick();
    mem_resp_valid = 0; lsu_resp_ready = 0;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0003; lsu_wen = 0; lsu_wmask = 4'h0;
    settle();
    checks++; if (lsu_req_ready !== 1'b1) begin
      errors++; $display("FAIL t6_lb_grant got %b want 1", lsu_req_ready); end
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    settle();
    checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, 32'h8000_0003, 1'b0, 4'h0}) begin
      errors++; $display("FAIL t6_lb_payload got %b %h %b %h", mem_req_valid, mem_addr, mem_wen, mem_wmask); end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_00AB; lsu_resp_ready = 1;
    settle();
    checks++; if ({lsu_resp_valid, lsu_rdata, lsu_resp_err} !== {1'b1, 32'hAB, 1'b0}) begin
      errors++; $display("FAIL t6_lb_resp got v=%b d=%h e=%b", lsu_resp_valid, lsu_rdata, lsu_resp_err); end
    tick();
    mem_resp_valid = 0; lsu_resp_ready = 0;
    $display("test_reset_mid done");
  endtask

  // Random traffic: model = pending request per master, LSU served first,
  // response routed to whoever was served. Slave delays stay inside the watchdog.
  task automatic test_random();
    logic        lsu_pend = 0, ifu_pend = 0, l_wen = 0, win_lsu, e_wen, er;
    logic [31:0] l_addr = 0, l_wdata = 0, i_addr = 0, e_addr, rd;
    logic [3:0]  l_wmask = 0, e_wmask;
    int          s, d, r;
    for (int t = 0; t < 40; t++) begin
      if (!lsu_pend && $urandom_range(0, 1) == 1) begin
        lsu_pend = 1; l_addr = $urandom; l_wen = 1'($urandom_range(0, 1)); l_wdata = $urandom;
        case ($urandom_range(0, 2))
          0: l_wmask = 4'b0001;
          1: l_wmask = 4'b0011;
          default: l_wmask = 4'b1111;
        endcase
        if (!l_wen) l_wmask = 4'b0000;
      end
      if (!ifu_pend && (!lsu_pend || $urandom_range(0, 1) == 1)) begin
        ifu_pend = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      lsu_req_valid = lsu_pend; lsu_addr = l_addr; lsu_wen = l_wen; lsu_wdata = l_wdata; lsu_wmask = l_wmask;
      ifu_req_valid = ifu_pend; ifu_addr = i_addr;
      win_lsu = lsu_pend;
      e_addr  = win_lsu ? l_addr : i_addr;
      e_wen   = win_lsu ? l_wen : 1'b0;
      e_wmask = win_lsu ? l_wmask : 4'h0;
      settle();
      checks++; if ({lsu_req_ready, ifu_req_ready} !== {1'b1, !lsu_pend}) begin
        errors++; $display("FAIL rnd%0d_grant got lsu/ifu ready %b want %b", t, {lsu_req_ready, ifu_req_ready}, {1'b1, !lsu_pend}); end
      tick();
      if (win_lsu) lsu_pend = 0; else ifu_pend = 0;
      lsu_req_valid = lsu_pend; ifu_req_valid = ifu_pend;
      s = $urandom_range(0, 2);
      for (int k = 0; k <= s; k++) begin
        mem_req_ready = (k == s);
        settle();
        checks++; if ({mem_req_valid, mem_addr, mem_wen, mem_wmask, lsu_req_ready, ifu_req_ready} !== {1'b1, e_addr, e_wen, e_wmask, 2'b00}) begin
          errors++; $display("FAIL rnd%0d_req got v=%b a=%h w=%b m=%h rdy=%b%b want a=%h w=%b m=%h", t, mem_req_valid, mem_addr, mem_wen, mem_wmask, lsu_req_ready, ifu_req_ready, e_addr, e_wen, e_wmask); end
        if (win_lsu && e_wen) begin
          checks++; if (mem_wdata !== l_wdata) begin
            errors++; $display("FAIL rnd%0d_wdata got %h want %h", t, mem_wdata, l_wdata); end
        end
        tick();
      end
      mem_req_ready = 0;
      d = $urandom_range(0, 1);
      for (int k = 0; k < d; k++) begin
        settle();
        checks++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b00) begin
          errors++; $display("FAIL rnd%0d_early_resp got %b want 00", t, {lsu_resp_valid, ifu_resp_valid}); end
        tick();
      end
      rd = $urandom; er = 1'($urandom_range(0, 1));
      mem_resp_valid = 1; mem_rdata = rd; mem_resp_err = er;
      r = $urandom_range(0, 1);
      for (int k = 0; k <= r; k++) begin
        if (win_lsu) lsu_resp_ready = (k == r); else ifu_resp_ready = (k == r);
        settle();
        checks++; if ({(win_lsu ? lsu_resp_valid : ifu_resp_valid), (win_lsu ? ifu_resp_valid : lsu_resp_valid),
                       (win_lsu ? lsu_rdata : ifu_rdata), (win_lsu ? lsu_resp_err : ifu_resp_err), mem_resp_ready}
                      !== {2'b10, rd, er, (k == r)}) begin
          errors++; $display("FAIL rnd%0d_resp owner_lsu=%b got lv=%b iv=%b ld=%h id=%h le=%b ie=%b mr=%b want d=%h e=%b mr=%b",
                             t, win_lsu, lsu_resp_valid, ifu_resp_valid, lsu_rdata, ifu_rdata, lsu_resp_err, ifu_resp_err, mem_resp_ready, rd, er, (k == r)); end
        tick();
      end
      mem_resp_valid = 0; mem_resp_err = 0; lsu_resp_ready = 0; ifu_resp_ready = 0;
      $display("rnd %0d owner=%s addr=%h wen=%b", t, win_lsu ? "LSU" : "IFU", e_addr, e_wen);
    end
    lsu_req_valid = 0; ifu_req_valid = 0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_ifu_only();
    test_priority();
    test_backpressure();
    test_timeout();
    test_stray();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
